// File: rtl/wreg_dbuf.sv
// wreg_dbuf: double-buffered weight register bank for one systolic-array column.
// Weights stream serially into a shadow bank while the active bank drives the PEs.
// A swap copies the whole shadow bank into the active bank in a single cycle.
// With DBUF=0 the shadow is bypassed and words are written straight into the active bank.
//
// state | meaning
// FILL  | accepting load words into the next lane (o_ready=1)
// FULL  | shadow holds a complete set, waiting for a swap (DBUF=1 only)
module wreg_dbuf #(
    parameter int WIDTH = 16,
    parameter int NLANE = 4,
    parameter int DBUF  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_swap,
    output logic [NLANE*WIDTH-1:0] o_data,
    output logic                   o_shadow_full,
    output logic                   o_swapped
);

    localparam int CW = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLANE - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           swap_pend_q, swap_pend_d;
    logic           swapped_q, swapped_d;
    logic [WIDTH-1:0] active_q [NLANE];
    logic [WIDTH-1:0] active_d [NLANE];
    logic [WIDTH-1:0] shadow_q [NLANE];
    logic [WIDTH-1:0] shadow_d [NLANE];
    logic           accept;

    // Handshake decodes the state register only, so o_ready never depends on i_valid.
    assign o_ready       = (state_q == FILL);
    assign o_shadow_full = (state_q == FULL);
    assign o_swapped     = swapped_q;
    assign accept        = i_valid && o_ready;

    // Next-state: clr dominates; otherwise fill/swap sequencing (DBUF=1) or direct write (DBUF=0).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        swap_pend_d = swap_pend_q;
        swapped_d   = 1'b0;
        active_d    = active_q;
        shadow_d    = shadow_q;

        if (clr) begin
            state_d     = FILL;
            cnt_d       = '0;
            swap_pend_d = 1'b0;
            for (int i = 0; i < NLANE; i++) begin
                active_d[i] = '0;
                shadow_d[i] = '0;
            end
        end else if (DBUF != 0) begin
            case (state_q)
                FILL: begin
                    // Early swap requests are remembered and fire once the set is complete.
                    if (i_swap) begin
                        swap_pend_d = 1'b1;
                    end
                    if (accept) begin
                        shadow_d[cnt_q] = i_data;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = FULL;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    // Shadow is kept after the swap but is overwritten by the next fill.
                    if (i_swap || swap_pend_q) begin
                        active_d    = shadow_q;
                        swap_pend_d = 1'b0;
                        state_d     = FILL;
                        swapped_d   = 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end else begin
            if (accept) begin
                active_d[cnt_q] = i_data;
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // State and bank registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            swap_pend_q <= 1'b0;
            swapped_q   <= 1'b0;
            for (int i = 0; i < NLANE; i++) begin
                active_q[i] <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            swap_pend_q <= swap_pend_d;
            swapped_q   <= swapped_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
        end
    end

    // Flatten the active bank onto the lane-ordered output bus.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NLANE; k++) begin
            o_data[k*WIDTH +: WIDTH] = active_q[k];
        end
    end

endmodule

// File: doc/wreg_dbuf.md
Name: wreg_dbuf

Overview:
- Parametrised, double-buffered weight register bank for one systolic-array column.
- Holds NLANE signed weights in an active bank that drives the PEs.
- The next weight set streams serially into a shadow bank over a valid/ready port.
- A swap request copies shadow to active in one cycle, so the array can run on old weights while new ones load.
- DBUF=0 gives a single-bank, direct-write mode.

Parameters:
- WIDTH, 16, bit width of each signed weight.
- NLANE, 4, number of weight lanes (>=1).
- DBUF, 1, 1 = shadow/active double buffer with swap; 0 = direct write into the active bank, no swap.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all state; highest priority after reset.
- i_valid  input  1  load word valid.
- o_ready  output  1  bank can accept a load word this cycle.
- i_data  input  WIDTH  signed load word, lane order 0..NLANE-1.
- i_swap  input  1  request to copy shadow to active (ignored when DBUF=0).
- o_data  output  NLANE*WIDTH  active weights; lane k at bits [k*WIDTH +: WIDTH], signed.
- o_shadow_full  output  1  shadow holds a complete weight set.
- o_swapped  output  1  one-cycle pulse, the cycle after active is updated.

Behaviour:
- Reset (rst_n=0, async) clears the following to 0: active bank, shadow bank, lane counter cnt, swap_pend, state, o_swapped. State becomes FILL. o_ready=1 after release.
- clr=1 at a clock edge has the same effect as reset, synchronously. It overrides any same-cycle load or swap. o_swapped=0 on the next cycle.
- Handshake: a word is accepted on an edge where i_valid && o_ready.
  - o_ready is combinational from state only: 1 in FILL, 0 in FULL.
  - i_data is don't-care when not accepted.
- cnt width is max(1,$clog2(NLANE)). It indexes the lane written by the next accepted word.
- DBUF=1, state FILL:
  - Accepted word is written to shadow[cnt].
  - If cnt==NLANE-1: cnt resets to 0 and state goes to FULL. Otherwise cnt increments.
  - i_swap in FILL sets swap_pend; it is not dropped.
- DBUF=1, state FULL:
  - o_shadow_full=1 and o_ready=0; i_valid is ignored.
  - Swap fires on an edge where FULL && (i_swap || swap_pend). On that edge: active <= shadow, swap_pend <= 0, state <= FILL.
  - o_swapped is 1 for the following cycle only.
  - Shadow contents are retained after the swap but treated as stale.
- Swap latency:
  - From the edge the last word is accepted, FULL is seen one cycle later.
  - A pending swap then fires at the first edge in FULL.
  - Minimum: the last word is accepted at edge t, the swap fires at t+1, and new o_data is visible after t+1.
- A swap request arriving on the same edge that accepts the last word sets swap_pend. The swap fires at the next edge.
- Repeated i_swap pulses during one fill collapse into a single pending swap.
- o_data changes only on a swap (DBUF=1), an accepted write (DBUF=0), reset or clr.
- DBUF=0:
  - Accepted word is written directly to active[cnt]; cnt wraps from NLANE-1 to 0.
  - State stays FILL and o_ready=1 always.
  - o_shadow_full=0, o_swapped=0, i_swap ignored, no shadow storage.
- NLANE=1: every accepted word completes a set; cnt stays 0.
- All outputs are registered except o_ready and o_shadow_full, which decode the state register.

Test Plan:
- Reset then load, WIDTH=16, NLANE=4, DBUF=1:
  - After reset, o_data=0 and o_ready=1.
  - Load 0x0001, 0x0002, 0xFFFF, 0x7FFF on 4 consecutive cycles -> o_shadow_full=1 and o_ready=0 one cycle later; o_data still 0.
- Swap:
  - Assert i_swap for 1 cycle in FULL -> next cycle lane0=1, lane1=2, lane2=-1, lane3=32767.
  - o_swapped pulses exactly 1 cycle; o_ready=1; o_shadow_full=0.
- Early swap:
  - Pulse i_swap after 2 of 4 words, then finish loading 0x0010..0x0013 with gaps in i_valid.
  - Swap fires at the first FULL edge with no further i_swap -> o_data lanes = 0x10..0x13; one o_swapped pulse.
- Backpressure:
  - In FULL, drive i_valid=1 with data 0x5555 for 3 cycles and no swap -> shadow and cnt are unchanged.
  - After the swap, the first accepted word lands in lane 0.
- Clear and async reset:
  - Assert clr on the same edge as i_swap in FULL -> o_data=0, state FILL, swap_pend=0, no o_swapped pulse.
  - Drop rst_n mid-fill between clock edges -> o_data=0 and cnt=0 immediately, without waiting for an edge.
- DBUF=0, NLANE=3:
  - Stream 7, 8, 9, 10 -> o_data lanes update per word, finishing at lane0=10, lane1=8, lane2=9.
  - o_ready stays 1; o_swapped stays 0; i_swap has no effect.
